mips_div_unit: RTL and testbench

- Multi-cycle iterative integer divider for the MIPS datapath. It implements DIV and DIVU, the subtract-based inverse of the adder path.
- Radix-2 restoring algorithm: one quotient bit per cycle, using a single WIDTH+1-bit subtractor.
- Results go to the HI/LO register write port: HI takes the remainder, LO takes the quotient.
- Controlled by a start/busy/done handshake from the pipeline stall logic.

---
 rtl/mips_div_pkg.sv | 20 ++
 rtl/mips_div_unit_sub_step.sv | 17 +
 rtl/mips_div_unit.sv | 121 ++++++++++++
 tb/tb_mips_div_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS DIV/DIVU unit.
package mips_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam int                      DIV_MAX_WIDTH     = 64;
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  // Iteration counter width, $clog2(WIDTH).
  function automatic int div_cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mips_div_unit_sub_step.sv
// Combinational WIDTH+1-bit trial subtract for one restoring-division step.
module div_sub_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             non_neg
);

  logic [WIDTH:0] full;

  assign full    = minuend - {1'b0, subtrahend};
  assign diff    = full[WIDTH-1:0];
  assign non_neg = ~full[WIDTH];

endmodule

// File: rtl/mips_div_unit.sv
// Radix-2 restoring divider for DIV/DIVU; HI = remainder, LO = quotient.
// Optional MIPS_DIV_EARLY_OUT_EN: divisor 0 or |divisor|=1 skips CALC.
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = div_cnt_width(WIDTH);

  div_state_e       state, state_nxt;
  logic [WIDTH-1:0] pr, dq, dvs;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg, dbz;

  logic             dvd_neg, dvs_neg, early;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] step_diff;
  logic             step_ok;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_abs = dvd_neg ? -dividend : dividend;
  assign dvs_abs = dvs_neg ? -divisor : divisor;

`ifdef MIPS_DIV_EARLY_OUT_EN
  assign early = (dvs_abs[WIDTH-1:1] == '0);
`else
  assign early = 1'b0;
`endif

  assign shifted = {pr, dq[WIDTH-1]};

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .minuend    (shifted),
    .subtrahend (dvs),
    .diff       (step_diff),
    .non_neg    (step_ok)
  );

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = early ? FIX : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pr          <= '0;
      dq          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz         <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvs   <= dvs_abs;
          q_neg <= dvd_neg ^ dvs_neg;
          r_neg <= dvd_neg;
          dbz   <= (divisor == '0);
          cnt   <= CNT_W'(WIDTH - 1);
          // Early-out preloads the magnitudes CALC would have produced.
          if (early && (dvs_abs == '0)) begin
            pr <= dvd_abs;
            dq <= '1;
          end else if (early) begin
            pr <= '0;
            dq <= dvd_abs;
          end else begin
            pr <= '0;
            dq <= dvd_abs;
          end
        end
        CALC: begin
          dq <= {dq[WIDTH-2:0], step_ok};
          pr <= step_ok ? step_diff : shifted[WIDTH-1:0];
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          // Divide-by-zero: pr holds |dividend|, so re-signing restores the dividend.
          quotient    <= dbz ? DIV_ZERO_QUOTIENT[WIDTH-1:0] : (q_neg ? -dq : dq);
          remainder   <= r_neg ? -pr : pr;
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit against an integer-arithmetic reference.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_tests = 0;
  int n_fail  = 0;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      z = 1'b0;
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
      end
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  function automatic int exp_latency(input logic s, input logic [31:0] b);
    int lat;
    lat = 34;
`ifdef MIPS_DIV_EARLY_OUT_EN
    if (b == 32'd0 || b == 32'd1 || (s && b == 32'hFFFF_FFFF)) lat = 2;
`endif
    return lat;
  endfunction

  // mode 0: plain division; mode 1: extra starts while busy and in the done cycle
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] eq, er;
    logic        ez;
    int          lat, cyc, done_cyc, busy_cnt, extra_done;
    ref_div(s, a, b, eq, er, ez);
    lat = exp_latency(s, b);
    @(negedge clk);
    is_signed = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; done_cyc = 0; busy_cnt = 0;
    while (done_cyc == 0 && cyc <= 60) begin
      if (done) done_cyc = cyc;
      else begin
        if (busy) busy_cnt++;
        if (mode == 1 && cyc == 10) begin
          start = 1'b1; is_signed = ~s; dividend = $urandom; divisor = $urandom;
        end else start = 1'b0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    chk("latency", 64'(done_cyc), 64'(lat));
    chk("busy_cycles", 64'(busy_cnt), 64'(lat - 1));
    chk("busy_at_done", {63'd0, busy}, 64'd0);
    chk("quotient", {32'd0, quotient}, {32'd0, eq});
    chk("remainder", {32'd0, remainder}, {32'd0, er});
    chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, ez});
    if (mode == 1) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_pulse", {63'd0, done}, 64'd0);
    chk("quotient_hold", {32'd0, quotient}, {32'd0, eq});
    if (mode == 1) begin
      chk("start_in_done_ignored", {63'd0, busy}, 64'd0);
      extra_done = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (done) extra_done++;
      end
      chk("no_second_done", 64'(extra_done), 64'd0);
    end
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_quotient", {32'd0, quotient}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_div(1'b0, 32'd100, 32'd7, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run_div(1'b0, 32'd1234, 32'd0, 0);
    run_div(1'b1, 32'hFFFF_FF00, 32'd0, 0);
    run_div(1'b0, 32'd5000, 32'd37, 1);

    // Asynchronous reset in the middle of CALC, after a result with div_by_zero set.
    run_div(1'b1, 32'hDEAD_BEEF, 32'd0, 0);
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd999; divisor = 32'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_quotient", {32'd0, quotient}, 64'd0);
    chk("arst_remainder", {32'd0, remainder}, 64'd0);
    chk("arst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_div(1'b0, 32'd999, 32'd10, 0);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: ;
        1: b = s && $urandom_range(0, 1) ? -32'($urandom_range(1, 20)) : 32'($urandom_range(1, 20));
        2: b = 32'd0;
        3: b = (s && $urandom_range(0, 1)) ? 32'hFFFF_FFFF : 32'd1;
        4: a = 32'h8000_0000;
        default: a = 32'($urandom_range(0, 50));
      endcase
      run_div(s, a, b, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
